// File: rtl/abr_ahb_pkg.sv
// rtl/abr_ahb_pkg.sv - AHB encodings and responder FSM states (ABR_AHB_DWORD_EN uses DATA_HI)
package abr_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_W  = 3'b010;
  localparam logic [2:0] HSIZE_DW = 3'b011;

  // DATA_HI is only reachable when the 64-bit split feature is compiled in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA    = 3'd1,
    ERR1    = 3'd2,
    ERR2    = 3'd3,
    DATA_HI = 3'd4
  } ahb_rsp_state_e;

endpackage

// File: rtl/abr_ahb_reg_responder.sv
// rtl/abr_ahb_reg_responder.sv - AHB-Lite to register-client responder (optional ABR_AHB_DWORD_EN)
module abr_ahb_reg_responder
  import abr_ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH    = 32,
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int CLIENT_ADDR_WIDTH = 16,
  parameter int CLIENT_DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [AHB_ADDR_WIDTH-1:0]    haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0]    hwdata_i,
  input  logic                         hsel_i,
  input  logic                         hwrite_i,
  input  logic                         hready_i,
  input  logic [1:0]                   htrans_i,
  input  logic [2:0]                   hsize_i,
  output logic                         hresp_o,
  output logic                         hreadyout_o,
  output logic [AHB_DATA_WIDTH-1:0]    hrdata_o,
  output logic                         dv_o,
  output logic                         write_o,
  output logic [CLIENT_ADDR_WIDTH-1:0] addr_o,
  output logic [CLIENT_DATA_WIDTH-1:0] wdata_o,
  input  logic [CLIENT_DATA_WIDTH-1:0] rdata_i,
  input  logic                         hold_i,
  input  logic                         err_i
);

  ahb_rsp_state_e                state_q, state_d;
  logic [CLIENT_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                          write_q, write_d;
  logic                          dword_q, dword_d;
  logic [CLIENT_DATA_WIDTH-1:0]  lo_q, lo_d;
  logic                          accept, legal, is_dword, done;
  logic                          hi_lane;
  logic [CLIENT_ADDR_WIDTH-1:0]  addr_cur;

  // Upper address bits and htrans[0] carry no information for this responder.
  logic unused_inputs;
  assign unused_inputs = ^{haddr_i[AHB_ADDR_WIDTH-1:CLIENT_ADDR_WIDTH], htrans_i[0]};

  assign accept = hsel_i & hready_i & htrans_i[1];

`ifdef ABR_AHB_DWORD_EN
  assign is_dword = (hsize_i == HSIZE_DW) && (haddr_i[2:0] == 3'b000);
`else
  assign is_dword = 1'b0;
`endif
  assign legal = ((hsize_i == HSIZE_W) && (haddr_i[1:0] == 2'b00)) || is_dword;

  // Next-state logic: a completing data phase may immediately take the next address phase.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    dword_d = dword_q;
    lo_d    = lo_q;
    done    = 1'b0;
    case (state_q)
      IDLE: done = 1'b1;
      DATA: begin
        if (!hold_i) begin
          if (err_i) begin
            state_d = ERR1;
          end else if (dword_q) begin
            state_d = DATA_HI;
            lo_d    = rdata_i;
          end else begin
            done = 1'b1;
          end
        end
      end
      DATA_HI: begin
        if (!hold_i) begin
          if (err_i) state_d = ERR1;
          else       done    = 1'b1;
        end
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      if (accept) begin
        if (legal) begin
          state_d = DATA;
          addr_d  = haddr_i[CLIENT_ADDR_WIDTH-1:0];
          write_d = hwrite_i;
          dword_d = is_dword;
        end else begin
          state_d = ERR1;
        end
      end
    end
  end

  // State and address-phase capture registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

`ifdef ABR_AHB_DWORD_EN
  // 64-bit transfer flag and captured low read word.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      dword_q <= 1'b0;
      lo_q    <= '0;
    end else begin
      dword_q <= dword_d;
      lo_q    <= lo_d;
    end
  end
`else
  assign dword_q = 1'b0;
  assign lo_q    = '0;
  logic unused_dword;
  assign unused_dword = ^{dword_d, lo_d};
`endif

  assign hi_lane  = (state_q == DATA_HI) | addr_q[2];
  assign addr_cur = (state_q == DATA_HI) ? (addr_q + CLIENT_ADDR_WIDTH'(4)) : addr_q;

  // Bus and client outputs; client side is zero outside a data phase.
  always_comb begin
    hresp_o     = 1'b0;
    hreadyout_o = 1'b1;
    hrdata_o    = '0;
    dv_o        = 1'b0;
    write_o     = 1'b0;
    addr_o      = '0;
    wdata_o     = '0;
    case (state_q)
      DATA, DATA_HI: begin
        dv_o        = 1'b1;
        write_o     = write_q;
        addr_o      = addr_cur;
        wdata_o     = hi_lane ? hwdata_i[63:32] : hwdata_i[31:0];
        hreadyout_o = ~hold_i & ~((state_q == DATA) & dword_q);
        if (!write_q) begin
          if (state_q == DATA_HI) hrdata_o = {rdata_i, lo_q};
          else if (!dword_q)      hrdata_o = hi_lane ? {rdata_i, 32'h0} : {32'h0, rdata_i};
        end
      end
      ERR1: begin
        hresp_o     = 1'b1;
        hreadyout_o = 1'b0;
      end
      ERR2:    hresp_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_abr_ahb_reg_responder.sv
// tb/tb_abr_ahb_reg_responder.sv - directed self-checking bench for abr_ahb_reg_responder
module tb_abr_ahb_reg_responder;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] haddr_i;
  logic [63:0] hwdata_i;
  logic        hsel_i, hwrite_i, hready_i;
  logic [1:0]  htrans_i;
  logic [2:0]  hsize_i;
  logic        hresp_o, hreadyout_o;
  logic [63:0] hrdata_o;
  logic        dv_o, write_o;
  logic [15:0] addr_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i;
  logic        hold_i, err_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  abr_ahb_reg_responder dut (
    .clk(clk), .rst_b(rst_b),
    .haddr_i(haddr_i), .hwdata_i(hwdata_i), .hsel_i(hsel_i), .hwrite_i(hwrite_i),
    .hready_i(hready_i), .htrans_i(htrans_i), .hsize_i(hsize_i),
    .hresp_o(hresp_o), .hreadyout_o(hreadyout_o), .hrdata_o(hrdata_o),
    .dv_o(dv_o), .write_o(write_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_i(rdata_i), .hold_i(hold_i), .err_i(err_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    hsel_i   = 1'b0;
    htrans_i = 2'b00;
    haddr_i  = '0;
    hwrite_i = 1'b0;
    hsize_i  = 3'b010;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    hsel_i   = 1'b1;
    htrans_i = 2'b10;
    haddr_i  = a;
    hwrite_i = wr;
    hsize_i  = sz;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    bus_idle();
    hready_i = 1'b1; hwdata_i = '0; rdata_i = '0; hold_i = 1'b0; err_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (hreadyout_o !== 1'b1 || hresp_o !== 1'b0 || hrdata_o !== 64'h0)
      $display("FAIL reset_bus: hreadyout=%b hresp=%b hrdata=%h, want 1 0 0", hreadyout_o, hresp_o, hrdata_o);
    else pass_cnt++;
    total_cnt++;
    if (dv_o !== 1'b0 || write_o !== 1'b0 || addr_o !== 16'h0 || wdata_o !== 32'h0)
      $display("FAIL reset_client: dv=%b write=%b addr=%h wdata=%h, want all 0", dv_o, write_o, addr_o, wdata_o);
    else pass_cnt++;
    step();
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    addr_phase(32'h0000_0010, 1'b1, 3'b010);
    step();
    bus_idle();
    hwdata_i = {32'h0, 32'h1};
    @(negedge clk);
    total_cnt++;
    if (dv_o !== 1'b1 || write_o !== 1'b1 || addr_o !== 16'h0010 || wdata_o !== 32'h1)
      $display("FAIL single_write: dv=%b write=%b addr=%h wdata=%h, want 1 1 0010 00000001", dv_o, write_o, addr_o, wdata_o);
    else pass_cnt++;
    total_cnt++;
    if (hreadyout_o !== 1'b1 || hresp_o !== 1'b0)
      $display("FAIL single_write_resp: hreadyout=%b hresp=%b, want 1 0", hreadyout_o, hresp_o);
    else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++;
    if (dv_o !== 1'b0)
      $display("FAIL single_write_one_cycle: dv=%b, want 0", dv_o);
    else pass_cnt++;
  endtask

  task automatic test_lane_steering();
    addr_phase(32'h0000_4004, 1'b1, 3'b010);
    step();
    bus_idle();
    hwdata_i = {32'hA5A5_0001, 32'h0};
    @(negedge clk);
    total_cnt++;
    if (wdata_o !== 32'hA5A5_0001 || addr_o !== 16'h4004)
      $display("FAIL lane_write_hi: wdata=%h addr=%h, want a5a50001 4004", wdata_o, addr_o);
    else pass_cnt++;
    step();
    addr_phase(32'h0000_4004, 1'b0, 3'b010);
    step();
    bus_idle();
    rdata_i = 32'hA5A5_0001;
    @(negedge clk);
    total_cnt++;
    if (hrdata_o !== 64'hA5A5_0001_0000_0000 || write_o !== 1'b0)
      $display("FAIL lane_read_hi: hrdata=%h write=%b, want a5a5000100000000 0", hrdata_o, write_o);
    else pass_cnt++;
    step();
    addr_phase(32'h0000_4000, 1'b0, 3'b010);
    step();
    bus_idle();
    rdata_i = 32'h0BAD_CAFE;
    @(negedge clk);
    total_cnt++;
    if (hrdata_o !== 64'h0000_0000_0BAD_CAFE)
      $display("FAIL lane_read_lo: hrdata=%h, want 000000000badcafe", hrdata_o);
    else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++;
    if (hrdata_o !== 64'h0)
      $display("FAIL lane_read_idle_zero: hrdata=%h, want 0", hrdata_o);
    else pass_cnt++;
  endtask

  task automatic test_hold();
    int waits;
    waits = 0;
    addr_phase(32'h0000_0008, 1'b0, 3'b010);
    step();
    bus_idle();
    hold_i  = 1'b1;
    rdata_i = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (hreadyout_o === 1'b0) waits++;
      total_cnt++;
      if (addr_o !== 16'h0008 || dv_o !== 1'b1)
        $display("FAIL hold_stable: cycle=%0d addr=%h dv=%b, want 0008 1", i, addr_o, dv_o);
      else pass_cnt++;
      step();
    end
    hold_i  = 1'b0;
    rdata_i = 32'h1234_5678;
    @(negedge clk);
    total_cnt++;
    if (waits != 3 || hreadyout_o !== 1'b1 || hrdata_o !== 64'h0000_0000_1234_5678)
      $display("FAIL hold_release: waits=%0d hreadyout=%b hrdata=%h, want 3 1 0000000012345678", waits, hreadyout_o, hrdata_o);
    else pass_cnt++;
    step();
  endtask

  task automatic test_error();
    logic dv_seen;
    addr_phase(32'h0000_0020, 1'b1, 3'b010);
    step();
    bus_idle();
    err_i = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (dv_o !== 1'b1 || hresp_o !== 1'b0)
      $display("FAIL err_data: dv=%b hresp=%b, want 1 0", dv_o, hresp_o);
    else pass_cnt++;
    step();
    err_i = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (hresp_o !== 1'b1 || hreadyout_o !== 1'b0 || dv_o !== 1'b0)
      $display("FAIL err_cycle1: hresp=%b hreadyout=%b dv=%b, want 1 0 0", hresp_o, hreadyout_o, dv_o);
    else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++;
    if (hresp_o !== 1'b1 || hreadyout_o !== 1'b1)
      $display("FAIL err_cycle2: hresp=%b hreadyout=%b, want 1 1", hresp_o, hreadyout_o);
    else pass_cnt++;
    step();
    @(negedge clk);
    total_cnt++;
    if (hresp_o !== 1'b0 || hreadyout_o !== 1'b1)
      $display("FAIL err_idle: hresp=%b hreadyout=%b, want 0 1", hresp_o, hreadyout_o);
    else pass_cnt++;
    dv_seen = 1'b0;
    addr_phase(32'h0000_0011, 1'b1, 3'b010);
    step();
    bus_idle();
    @(negedge clk);
    dv_seen |= dv_o;
    total_cnt++;
    if (hresp_o !== 1'b1 || hreadyout_o !== 1'b0)
      $display("FAIL unaligned_cycle1: hresp=%b hreadyout=%b, want 1 0", hresp_o, hreadyout_o);
    else pass_cnt++;
    step();
    @(negedge clk);
    dv_seen |= dv_o;
    total_cnt++;
    if (hresp_o !== 1'b1 || hreadyout_o !== 1'b1)
      $display("FAIL unaligned_cycle2: hresp=%b hreadyout=%b, want 1 1", hresp_o, hreadyout_o);
    else pass_cnt++;
    step();
    @(negedge clk);
    dv_seen |= dv_o;
    total_cnt++;
    if (dv_seen !== 1'b0 || hresp_o !== 1'b0)
      $display("FAIL unaligned_no_access: dv_seen=%b hresp=%b, want 0 0", dv_seen, hresp_o);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignored();
    hsel_i   = 1'b1;
    htrans_i = 2'b01;
    haddr_i  = 32'h0000_0040;
    hwrite_i = 1'b1;
    step();
    bus_idle();
    @(negedge clk);
    total_cnt++;
    if (dv_o !== 1'b0 || hreadyout_o !== 1'b1 || hresp_o !== 1'b0)
      $display("FAIL busy_ignored: dv=%b hreadyout=%b hresp=%b, want 0 1 0", dv_o, hreadyout_o, hresp_o);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a;
    logic [31:0] exp_w;
    addr_phase(32'h0000_4000, 1'b1, 3'b010);
    step();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) addr_phase(32'h0000_4000 + 32'(4 * (i + 1)), 1'b1, 3'b010);
      else       bus_idle();
      hwdata_i = {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
      exp_a = 16'h4000 + 16'(4 * i);
      exp_w = exp_a[2] ? (32'hB000_0000 + 32'(i)) : (32'hA000_0000 + 32'(i));
      @(negedge clk);
      total_cnt++;
      if (dv_o !== 1'b1 || addr_o !== exp_a || wdata_o !== exp_w || hreadyout_o !== 1'b1)
        $display("FAIL b2b_beat%0d: dv=%b addr=%h wdata=%h hreadyout=%b, want 1 %h %h 1", i, dv_o, addr_o, wdata_o, hreadyout_o, exp_a, exp_w);
      else pass_cnt++;
      step();
    end
    @(negedge clk);
    total_cnt++;
    if (dv_o !== 1'b0)
      $display("FAIL b2b_end: dv=%b, want 0", dv_o);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_transfer();
    addr_phase(32'h0000_0030, 1'b0, 3'b010);
    step();
    bus_idle();
    hold_i  = 1'b1;
    rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    total_cnt++;
    if (hreadyout_o !== 1'b0 || dv_o !== 1'b1)
      $display("FAIL rst_mid_pre: hreadyout=%b dv=%b, want 0 1", hreadyout_o, dv_o);
    else pass_cnt++;
    #2;
    rst_b = 1'b0;
    #1;
    total_cnt++;
    if (dv_o !== 1'b0 || write_o !== 1'b0 || addr_o !== 16'h0 || wdata_o !== 32'h0 ||
        hreadyout_o !== 1'b1 || hresp_o !== 1'b0 || hrdata_o !== 64'h0)
      $display("FAIL rst_mid: dv=%b write=%b addr=%h wdata=%h hreadyout=%b hresp=%b hrdata=%h, want reset values",
               dv_o, write_o, addr_o, wdata_o, hreadyout_o, hresp_o, hrdata_o);
    else pass_cnt++;
    step();
    hold_i = 1'b0;
    rst_b  = 1'b1;
    step();
    @(negedge clk);
    total_cnt++;
    if (dv_o !== 1'b0 || hreadyout_o !== 1'b1)
      $display("FAIL rst_mid_dropped: dv=%b hreadyout=%b, want 0 1", dv_o, hreadyout_o);
    else pass_cnt++;
  endtask

`ifdef ABR_AHB_DWORD_EN
  task automatic test_dword();
    addr_phase(32'h0000_4000, 1'b0, 3'b011);
    step();
    bus_idle();
    rdata_i = 32'h1111_0000;
    @(negedge clk);
    total_cnt++;
    if (dv_o !== 1'b1 || addr_o !== 16'h4000 || hreadyout_o !== 1'b0)
      $display("FAIL dword_lo: dv=%b addr=%h hreadyout=%b, want 1 4000 0", dv_o, addr_o, hreadyout_o);
    else pass_cnt++;
    step();
    rdata_i = 32'h2222_0001;
    @(negedge clk);
    total_cnt++;
    if (dv_o !== 1'b1 || addr_o !== 16'h4004 || hreadyout_o !== 1'b1 || hrdata_o !== 64'h2222_0001_1111_0000)
      $display("FAIL dword_hi: dv=%b addr=%h hreadyout=%b hrdata=%h, want 1 4004 1 2222000111110000", dv_o, addr_o, hreadyout_o, hrdata_o);
    else pass_cnt++;
    step();
  endtask
`else
  task automatic test_dword();
    addr_phase(32'h0000_4000, 1'b0, 3'b011);
    step();
    bus_idle();
    @(negedge clk);
    total_cnt++;
    if (dv_o !== 1'b0 || hresp_o !== 1'b1 || hreadyout_o !== 1'b0)
      $display("FAIL dword_illegal: dv=%b hresp=%b hreadyout=%b, want 0 1 0", dv_o, hresp_o, hreadyout_o);
    else pass_cnt++;
    repeat (2) step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_lane_steering();
    test_hold();
    test_error();
    test_busy_ignored();
    test_back_to_back();
    test_dword();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
